// File: rtl/lcd_text_pkg.sv
// Shared constants, state encoding and helpers for the LCD text writer.
package lcd_text_pkg;

  // Default screen geometry: 800x480 px with 8x16 px glyphs.
  localparam int unsigned DEF_COLUMNS = 100;
  localparam int unsigned DEF_ROWS    = 30;

  // Character codes the writer interprets.
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_TAB   = 7'h09;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_FF    = 7'h0C;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_TILDE = 7'h7E;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_e;

  // True for codes that produce a glyph write.
  function automatic logic is_printable(input logic [6:0] ch);
    return (ch >= CH_SPACE) && (ch <= CH_TILDE);
  endfunction

endpackage

// File: rtl/lcd_text_addr.sv
// Maps a logical (row, col) cursor plus the scroll offset to a text RAM address.
module lcd_text_addr
  import lcd_text_pkg::*;
#(
  parameter int unsigned COLUMNS = DEF_COLUMNS,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned ADDR_W  = $clog2(COLUMNS * ROWS),
  parameter int unsigned ROW_W   = $clog2(ROWS),
  parameter int unsigned COL_W   = $clog2(COLUMNS)
) (
  input  logic [ROW_W-1:0]  top_row_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  output logic [ADDR_W-1:0] wr_addr_o
);

  logic [ROW_W:0]   sum_c;
  logic [ROW_W-1:0] phys_c;

  // Modular row add via a single conditional subtract, then row*COLUMNS + col.
  always_comb begin
    sum_c = {1'b0, top_row_i} + {1'b0, row_i};
    if (sum_c >= (ROW_W+1)'(ROWS)) begin
      phys_c = ROW_W'(sum_c - (ROW_W+1)'(ROWS));
    end else begin
      phys_c = ROW_W'(sum_c);
    end
    wr_addr_o = ADDR_W'(ADDR_W'(phys_c) * ADDR_W'(COLUMNS)) + ADDR_W'(col_i);
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Terminal-style character writer for the LCD text RAM with circular-row scrolling.
// Optional feature: define LCD_TEXT_WRITER_TAB_EN to make 0x09 advance to the next tab stop.
module lcd_text_writer
  import lcd_text_pkg::*;
#(
  parameter int unsigned COLUMNS = DEF_COLUMNS,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned ADDR_W  = $clog2(COLUMNS * ROWS),
  parameter int unsigned ROW_W   = $clog2(ROWS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_char,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic [ROW_W-1:0]  top_row,
  output logic              busy
);

  localparam int unsigned COL_W = $clog2(COLUMNS);
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [6:0]        wr_data_q, wr_data_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              line_adv_c;
  logic              printed_c;
  logic [ROW_W-1:0]  top_inc_c;
  logic [ROW_W-1:0]  a_row_c;
  logic [COL_W-1:0]  a_col_c;
  logic [ADDR_W-1:0] addr_c;
`ifdef LCD_TEXT_WRITER_TAB_EN
  logic [COL_W:0]    tab_next_c;
`endif

  assign accept_c  = in_valid && in_ready_q;
  assign top_inc_c = (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + ROW_W'(1);

  // Address-generator operands: cursor for glyphs, (0,0) on the old top row for the first
  // clear write of a scroll, bottom logical row for the rest of a row clear.
  always_comb begin
    a_row_c = row_q;
    a_col_c = col_q;
    if (state_q == CLEAR_ROW) begin
      a_col_c = cnt_q[COL_W-1:0];
      a_row_c = (cnt_q == '0) ? '0 : ROW_W'(ROWS - 1);
    end else if (!is_printable(in_char)) begin
      a_row_c = '0;
      a_col_c = '0;
    end
  end

  lcd_text_addr #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS),
    .ADDR_W  (ADDR_W),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) u_addr (
    .top_row_i (top_q),
    .row_i     (a_row_c),
    .col_i     (a_col_c),
    .wr_addr_o (addr_c)
  );

  // Next-state, cursor and registered-output decode.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    line_adv_c = 1'b0;
    printed_c  = 1'b0;
`ifdef LCD_TEXT_WRITER_TAB_EN
    tab_next_c = ({1'b0, col_q} | (COL_W+1)'(7)) + (COL_W+1)'(1);
`endif

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (is_printable(in_char)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_c;
            wr_data_d = in_char;
            printed_c = 1'b1;
            if (col_q == COL_W'(COLUMNS - 1)) begin
              col_d      = '0;
              line_adv_c = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            case (in_char)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d      = '0;
                line_adv_c = 1'b1;
              end
              CH_BS: begin
                if (col_q != '0) col_d = col_q - COL_W'(1);
              end
              CH_FF: begin
                state_d   = CLEAR_ALL;
                col_d     = '0;
                row_d     = '0;
                top_d     = '0;
                cnt_d     = CNT_W'(1);
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = CH_SPACE;
              end
`ifdef LCD_TEXT_WRITER_TAB_EN
              CH_TAB: begin
                if (tab_next_c >= (COL_W+1)'(COLUMNS)) begin
                  col_d      = '0;
                  line_adv_c = 1'b1;
                end else begin
                  col_d = tab_next_c[COL_W-1:0];
                end
              end
`endif
              default: ;
            endcase
          end

          if (line_adv_c) begin
            if (row_q != ROW_W'(ROWS - 1)) begin
              row_d = row_q + ROW_W'(1);
            end else if (printed_c) begin
              // Glyph write goes out first; the scroll starts one cycle later.
              state_d = CLEAR_ROW;
              cnt_d   = '0;
            end else begin
              state_d   = CLEAR_ROW;
              top_d     = top_inc_c;
              cnt_d     = CNT_W'(1);
              wr_en_d   = 1'b1;
              wr_addr_d = addr_c;
              wr_data_d = CH_SPACE;
            end
          end
        end
      end

      CLEAR_ROW: begin
        if (cnt_q == CNT_W'(COLUMNS)) begin
          state_d = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_c;
          wr_data_d = CH_SPACE;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == '0) top_d = top_inc_c;
        end
      end

      CLEAR_ALL: begin
        if (cnt_q == CNT_W'(ROWS * COLUMNS)) begin
          state_d = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = CH_SPACE;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = ~in_ready_d;
  end

  // State and output registers; reset starts a full-screen clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR_ALL;
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign top_row  = top_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: a cursor/screen model predicts every RAM write
// with its cycle, and a monitor checks writes, handshake and reset outputs.
module tb_lcd_text_writer;

  localparam int C  = 100;
  localparam int R  = 30;
  localparam int AW = $clog2(C * R);
  localparam int RW = $clog2(R);

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_char;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [RW-1:0] top_row;
  logic          busy;

  lcd_text_writer #(.COLUMNS(C), .ROWS(R)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .top_row  (top_row),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_from = 1 << 30;
  int   busy_from  = 1 << 30;
  bit   in_rst = 1'b1;
  int   m_col = 0, m_row = 0, m_top = 0;

  bit   mon_rdy, mon_busy;
  exp_t mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares every observed cycle against the predicted schedule.
  always @(negedge clock) begin
    if (!reset_n) begin
      checks++;
      if (wr_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
          wr_addr !== '0 || wr_data !== '0 || top_row !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got wr_en=%b in_ready=%b busy=%b addr=%0d data=%h top=%0d want all 0",
                 cyc, wr_en, in_ready, busy, wr_addr, wr_data, top_row);
      end
    end else if (!in_rst) begin
      mon_rdy  = (cyc >= ready_from);
      mon_busy = (cyc >= busy_from) && !mon_rdy;
      checks++;
      if (in_ready !== mon_rdy) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got %b want %b", cyc, in_ready, mon_rdy);
      end
      checks++;
      if (busy !== mon_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, mon_busy);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write cyc=%0d want addr=%0d data=%h at cyc=%0d", cyc, mon_e.addr, mon_e.data, mon_e.cyc);
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h want no write", cyc, wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_addr !== AW'(mon_e.addr) || wr_data !== 7'(mon_e.data) || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL write cyc=%0d got addr=%0d data=%h want addr=%0d data=%h cyc=%0d",
                     cyc, wr_addr, wr_data, mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
      end else if (wr_en !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL wr_en_unknown cyc=%0d got %b want 0 or 1", cyc, wr_en);
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_w(input int a, input int d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Line advance on the model screen; d delays the scroll clear by one cycle after a glyph.
  task automatic model_newline(input int n, input int d);
    int bottom;
    if (m_row < R - 1) begin
      m_row++;
    end else begin
      m_top  = (m_top + 1) % R;
      bottom = (m_top + R - 1) % R;
      for (int c = 0; c < C; c++) push_w(bottom * C + c, 32, n + 1 + d + c);
      ready_from = n + 1 + d + C;
    end
  endtask

  task automatic model_accept(input int ch, input int n);
    int nxt;
    ready_from = n + 1;
    if (ch >= 32 && ch <= 126) begin
      push_w(((m_top + m_row) % R) * C + m_col, ch, n + 1);
      m_col++;
      if (m_col == C) begin
        m_col = 0;
        model_newline(n, 1);
      end
    end else if (ch == 13) begin
      m_col = 0;
    end else if (ch == 10) begin
      m_col = 0;
      model_newline(n, 0);
    end else if (ch == 8) begin
      if (m_col > 0) m_col--;
    end else if (ch == 12) begin
      for (int a = 0; a < C * R; a++) push_w(a, 32, n + 1 + a);
      m_col = 0;
      m_row = 0;
      m_top = 0;
      ready_from = n + 1 + C * R;
    end
`ifdef LCD_TEXT_WRITER_TAB_EN
    else if (ch == 9) begin
      nxt = (m_col / 8 + 1) * 8;
      if (nxt >= C) begin
        m_col = 0;
        model_newline(n, 0);
      end else begin
        m_col = nxt;
      end
    end
`endif
  endtask

  task automatic send(input int ch);
    int w = 0;
    in_char  = 7'(ch);
    in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      if (w >= 5000) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout cyc=%0d got in_ready=%b want 1 within 5000 cycles", cyc, in_ready);
        in_valid = 1'b0;
        return;
      end
      w++;
      step();
    end
    checks++;
    if (top_row !== RW'(m_top)) begin
      errors++;
      $display("FAIL top_row cyc=%0d got %0d want %0d", cyc, top_row, m_top);
    end
    model_accept(ch, cyc);
    step();
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    in_rst   = 1'b1;
    exp_q.delete();
    ready_from = 1 << 30;
    busy_from  = 1 << 30;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_en_immediate got %b want 0", wr_en);
    end
    repeat (3) step();
    reset_n = 1'b1;
    m_col = 0;
    m_row = 0;
    m_top = 0;
    for (int a = 0; a < C * R; a++) push_w(a, 32, cyc + 1 + a);
    ready_from = cyc + 1 + C * R;
    busy_from  = cyc + 1;
    in_rst = 1'b0;
  endtask

  function automatic int rand_char();
    int r = int'($urandom_range(0, 99));
    int o;
    if (r < 72) return int'($urandom_range(32, 126));
    if (r < 82) return 10;
    if (r < 87) return 13;
    if (r < 92) return 8;
    if (r < 96) return 9;
    o = int'($urandom_range(0, 31));
    if (o == 12 || o == 10 || o == 13 || o == 8) o = 127;
    return o;
  endfunction

  int ch_r;

  initial begin
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_char  = '0;
    step();
    do_reset();

    // Single printables, then controls on row 0.
    send(8'h41);
    send(8'h42);
    send(13);
    send(8);
    send(8'h41);
    send(8'h42);
    send(13);
    send(8'h43);

    // Column wrap from column 0.
    send(13);
    for (int i = 0; i < 101; i++) send(8'h30 + (i % 10));

    // Scroll via LF on the last row, then a glyph on the new bottom row.
    while (m_row < R - 1) send(10);
    send(10);
    send(8'h58);

    // Tab stop.
    send(13);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(9);
    send(8'h5A);

    // Form feed, then a printable wrap at the last cell of the last row.
    send(12);
    while (m_row < R - 1) send(10);
    for (int i = 0; i < C; i++) send(8'h61 + (i % 26));
    send(8'h2A);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) gap(int'($urandom_range(1, 3)));
      ch_r = rand_char();
      send(ch_r);
    end

    // Reset in the middle of a scroll.
    while (m_row < R - 1) send(10);
    send(10);
    gap(30);
    do_reset();
    send(8'h51);

    // Drain outstanding writes.
    in_valid = 1'b0;
    for (int k = 0; k < 4000 && exp_q.size() > 0; k++) step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending writes want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Terminal-style producer for the LCD text buffer. It accepts a stream of 7-bit ASCII characters over a valid/ready handshake, interprets a small set of control codes, and writes glyph codes into the text RAM that the display path reads and renders through the font lookup. Scrolling uses a circular row buffer: the block exports a `top_row` offset that the display path adds to its row index, so scrolling never copies RAM contents.

## Interface
- `COLUMNS`, default 100: characters per row (800 px / 8 px glyphs).
- `ROWS`, default 30: text rows (480 px / 16 px glyphs).
- `ADDR_W`, default `$clog2(COLUMNS*ROWS)`: width of the text RAM address.
- `ROW_W`, default `$clog2(ROWS)`: width of a row index.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  the block can accept a character this cycle.
- `in_char`  in  7  ASCII code.
- `wr_en`  out  1  text RAM write strobe.
- `wr_addr`  out  ADDR_W  text RAM address, equal to physical_row*COLUMNS + col.
- `wr_data`  out  7  glyph code to write.
- `top_row`  out  ROW_W  physical row shown at the top of the screen.
- `busy`  out  1  a clear is in progress; this is the complement of `in_ready`.

## Operation
- **State:** cursor `(col, row)` is logical. The physical row is `(top_row + row) mod ROWS`, computed without a divider using a conditional subtract.
- **FSM states:**
  - IDLE: `in_ready=1`.
  - CLEAR_ROW: writes `0x20` to every column of one physical row.
  - CLEAR_ALL: writes `0x20` to all `ROWS*COLUMNS` addresses in ascending order.
- **Accept:** a character is accepted on `in_valid && in_ready`. Actions for an accepted character in IDLE:
  - `0x20`–`0x7E`: write the character at the cursor, then advance `col`. When `col==COLUMNS-1`, advance instead performs a line advance with `col=0`.
  - `0x0D` (CR): `col=0`. No write.
  - `0x0A` (LF): `col=0`, then line advance.
  - `0x08` (BS): if `col>0`, `col--`. No write and no erase. At `col==0` it is a no-op.
  - `0x0C` (FF): go to CLEAR_ALL; cursor (0,0); `top_row=0`.
  - Any other code is consumed and ignored.
- **Line advance:**
  - If `row<ROWS-1`: `row++`.
  - Otherwise: `top_row = (top_row+1) mod ROWS`, `row` stays at `ROWS-1`, and the FSM enters CLEAR_ROW targeting the new bottom physical row. That row equals the old `top_row`.
- **Clear completion:** after the final clear write, the FSM returns to IDLE.
- **Reset:** on assertion, the FSM enters CLEAR_ALL, with cursor (0,0) and `top_row=0`. Every output resets to 0. Reset mid-clear restarts the full clear.

## Timing
- **Handshake:** `in_ready` is registered. Its value is 1 only in IDLE and 0 in CLEAR_ROW and CLEAR_ALL.
- **Write latency:** a printable character accepted in cycle N produces `wr_en=1`, with its address and data, in cycle N+1. With `in_valid` held high, the block sustains one character per cycle.
- **`wr_en` behaviour:** high for exactly one cycle per printable character. It stays low for control codes.
- **CLEAR_ROW:** entered in cycle N+1 after the accepting cycle N. It issues COLUMNS consecutive writes in cycles N+1 … N+COLUMNS, starting at column 0. `in_ready` returns to 1 in cycle N+COLUMNS+1.
- **Wrap with printable:** a printable at the last column of the last row writes in N+1 and enters CLEAR_ROW in N+2, so its own write is never overwritten.
- **CLEAR_ALL:** issues `ROWS*COLUMNS` consecutive writes. `in_ready` goes high in the following cycle.
- **`top_row`:** updates in the same cycle the corresponding CLEAR_ROW begins.

## Configuration
- **`LCD_TEXT_WRITER_TAB_EN` defined:** `0x09` (TAB) advances `col` to the next multiple of 8. No write occurs.
  - If the next multiple of 8 is ≥ COLUMNS, TAB performs a line advance with `col=0`.
- **Not defined:** `0x09` is consumed and ignored like other unsupported codes.

## Structure
- **Package `lcd_text_pkg`:**
  - Character-code constants: `CH_SPACE`, `CH_BS`, `CH_TAB`, `CH_LF`, `CH_FF`, `CH_CR`.
  - FSM state enum: IDLE, CLEAR_ROW, CLEAR_ALL.
  - Default geometry constants.
- **Sub-module `lcd_text_addr`:** combinational. Inputs are `top_row`, `row` and `col`; output is the physical `wr_addr`, covering the modular row add and the multiply by COLUMNS.

## Test plan
- **Reset clear:** release reset → `in_ready=0` for 3000 cycles, with `wr_en` high throughout and addresses 0…2999 all carrying data `0x20`; `in_ready=1` on the next cycle.
- **Single printable:** after the clear, send `'A'` (0x41) → one cycle later `wr_en=1`, `wr_addr=0`, `wr_data=0x41`. Then `'B'` → `wr_addr=1`.
- **Column wrap:** send 101 printables from (0,0) → the 101st character writes to `wr_addr=100`.
- **Scroll:** with the cursor on row 29, send LF → `top_row` becomes 1 and 100 writes of `0x20` hit addresses 0…99, with `in_ready` low for exactly 100 cycles. Then `'X'` writes to `wr_addr=0`.
- **Controls:** at `col=0`, BS gives no write and `col` unchanged. Sending `'A'`, `'B'`, CR, `'C'` writes `'C'` at address 0. FF → 3000-cycle clear and `top_row=0`.
- **Tab and reset:** with `LCD_TEXT_WRITER_TAB_EN`, TAB at `col=3` followed by `'Z'` writes `'Z'` at `col=8`. Asserting reset mid-scroll → `wr_en=0` immediately and the full clear restarts.
